// File: rtl/multi_zero_run_detector.sv
// Multi-channel Mealy detector: flags a 0 that ends a run of at least
// min_run consecutive 1s on each serial channel, reports the run length
// and keeps a saturating aggregate hit count.
module multi_zero_run_detector #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned HIT_W    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      en,
  input  logic [CNT_W-1:0]          min_run,
  input  logic [CHANNELS-1:0]       x_in,
  output logic [CHANNELS-1:0]       y_out,
  output logic [CHANNELS-1:0]       y_reg,
  output logic [CHANNELS*CNT_W-1:0] run_len,
  output logic [HIT_W-1:0]          hit_count
);

  localparam int unsigned POP_W = $clog2(CHANNELS + 1);
  localparam int unsigned SUM_W = ((HIT_W > POP_W) ? HIT_W : POP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t           state_q [CHANNELS];
  state_t           state_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_d   [CHANNELS];
  logic [CNT_W:0]   cnt_wide[CHANNELS];
  logic [CNT_W-1:0] cnt_sat [CHANNELS];
  logic [CNT_W-1:0] len_q   [CHANNELS];

  logic [CNT_W-1:0] min_eff;
  logic [CNT_W:0]   min_eff_w;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] hit_sum;
  logic [HIT_W-1:0] hit_d;

  // A zero threshold behaves as a threshold of one.
  assign min_eff   = (min_run == '0) ? CNT_W'(1) : min_run;
  assign min_eff_w = {1'b0, min_eff};

  // Per-channel next state, counter and Mealy detect.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      y_out[i]    = 1'b0;
      cnt_wide[i] = {1'b0, cnt_q[i]} + (CNT_W+1)'(1);
      cnt_sat[i]  = cnt_wide[i][CNT_W] ? CNT_MAX : cnt_wide[i][CNT_W-1:0];
      if (en) begin
        case (state_q[i])
          IDLE: begin
            if (x_in[i]) begin
              cnt_d[i]   = CNT_W'(1);
              state_d[i] = (min_eff == CNT_W'(1)) ? ARMED : RUN;
            end else begin
              cnt_d[i]   = '0;
            end
          end
          RUN: begin
            if (x_in[i]) begin
              cnt_d[i]   = cnt_sat[i];
              state_d[i] = (cnt_wide[i] >= min_eff_w) ? ARMED : RUN;
            end else begin
              cnt_d[i]   = '0;
              state_d[i] = IDLE;
            end
          end
          ARMED: begin
            if (x_in[i]) begin
              cnt_d[i]   = cnt_sat[i];
            end else begin
              y_out[i]   = 1'b1;
              cnt_d[i]   = '0;
              state_d[i] = IDLE;
            end
          end
          default: begin
            cnt_d[i]   = '0;
            state_d[i] = IDLE;
          end
        endcase
      end
    end
  end

  // Number of channels detecting this cycle and the saturated new total.
  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop = pop + POP_W'(y_out[i]);
    end
    hit_sum = SUM_W'(hit_count) + SUM_W'(pop);
    hit_d   = (hit_sum > SUM_W'(HIT_MAX)) ? HIT_MAX : hit_sum[HIT_W-1:0];
  end

  // Channel state and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Registered detect, captured run lengths and aggregate hit count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_reg     <= '0;
      hit_count <= '0;
      for (int i = 0; i < CHANNELS; i++) len_q[i] <= '0;
    end else if (clear) begin
      y_reg     <= '0;
      hit_count <= '0;
      for (int i = 0; i < CHANNELS; i++) len_q[i] <= '0;
    end else if (en) begin
      y_reg     <= y_out;
      hit_count <= hit_d;
      for (int i = 0; i < CHANNELS; i++) begin
        if (y_out[i]) len_q[i] <= cnt_q[i];
      end
    end else begin
      y_reg     <= '0;
    end
  end

  // Flatten captured lengths onto the run_len bus.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_len
    assign run_len[g*CNT_W +: CNT_W] = len_q[g];
  end

endmodule

// File: tb/tb_multi_zero_run_detector.sv
// Directed self-checking bench for multi_zero_run_detector. A second
// instance with a 3-bit hit counter shares all inputs to exercise saturation.
module tb_multi_zero_run_detector;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        en;
  logic [3:0]  min_run;
  logic [3:0]  x_in;
  logic [3:0]  y_out, y_out_s;
  logic [3:0]  y_reg, y_reg_s;
  logic [15:0] run_len, run_len_s;
  logic [15:0] hit_count;
  logic [2:0]  hit_s;

  int checks = 0;
  int errors = 0;

  multi_zero_run_detector #(.CHANNELS(4), .CNT_W(4), .HIT_W(16)) dut (
    .clock(clock), .reset(reset), .clear(clear), .en(en), .min_run(min_run),
    .x_in(x_in), .y_out(y_out), .y_reg(y_reg), .run_len(run_len),
    .hit_count(hit_count)
  );

  multi_zero_run_detector #(.CHANNELS(4), .CNT_W(4), .HIT_W(3)) dut_s (
    .clock(clock), .reset(reset), .clear(clear), .en(en), .min_run(min_run),
    .x_in(x_in), .y_out(y_out_s), .y_reg(y_reg_s), .run_len(run_len_s),
    .hit_count(hit_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply x for one enabled edge, leaving time at edge+1.
  task automatic cyc(input logic [3:0] x);
    x_in = x;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (y_out !== 4'h0) begin errors++; $display("FAIL reset_y_out got %h exp 0", y_out); end
    checks++; if (y_reg !== 4'h0) begin errors++; $display("FAIL reset_y_reg got %h exp 0", y_reg); end
    checks++; if (run_len !== 16'h0) begin errors++; $display("FAIL reset_run_len got %h exp 0", run_len); end
    checks++; if (hit_count !== 16'h0) begin errors++; $display("FAIL reset_hit got %0d exp 0", hit_count); end
    checks++; if (hit_s !== 3'd0) begin errors++; $display("FAIL reset_hit_s got %0d exp 0", hit_s); end
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_min1();
    en = 1'b1; min_run = 4'd1;
    for (int k = 0; k < 3; k++) begin
      x_in = 4'b0001; #1;
      checks++; if (y_out !== 4'h0) begin errors++; $display("FAIL min1_y_out_run%0d got %h exp 0", k, y_out); end
      @(posedge clock); #1;
    end
    x_in = 4'b0000; #1;
    checks++; if (y_out !== 4'b0001) begin errors++; $display("FAIL min1_y_out_det got %h exp 1", y_out); end
    @(posedge clock); #1;
    checks++; if (y_reg !== 4'b0001) begin errors++; $display("FAIL min1_y_reg got %h exp 1", y_reg); end
    checks++; if (run_len[3:0] !== 4'd3) begin errors++; $display("FAIL min1_run_len got %0d exp 3", run_len[3:0]); end
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL min1_hit got %0d exp 1", hit_count); end
    checks++; if (y_out !== 4'h0) begin errors++; $display("FAIL min1_y_out_idle got %h exp 0", y_out); end
    cyc(4'b0000);
    checks++; if (y_reg !== 4'h0) begin errors++; $display("FAIL min1_y_reg_clr got %h exp 0", y_reg); end
  endtask

  task automatic test_min_run();
    min_run = 4'd3;
    cyc(4'b0010); cyc(4'b0010);
    x_in = 4'b0000; #1;
    checks++; if (y_out !== 4'h0) begin errors++; $display("FAIL thr_short_y_out got %h exp 0", y_out); end
    @(posedge clock); #1;
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL thr_short_hit got %0d exp 1", hit_count); end
    cyc(4'b0010); cyc(4'b0010); cyc(4'b0010);
    x_in = 4'b0000; #1;
    checks++; if (y_out !== 4'b0010) begin errors++; $display("FAIL thr_det_y_out got %h exp 2", y_out); end
    @(posedge clock); #1;
    checks++; if (run_len[7:4] !== 4'd3) begin errors++; $display("FAIL thr_run_len got %0d exp 3", run_len[7:4]); end
    checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL thr_hit got %0d exp 2", hit_count); end
    min_run = 4'd0;
    cyc(4'b0010);
    x_in = 4'b0000; #1;
    checks++; if (y_out !== 4'b0010) begin errors++; $display("FAIL zero_thr_y_out got %h exp 2", y_out); end
    @(posedge clock); #1;
    checks++; if (run_len[7:4] !== 4'd1) begin errors++; $display("FAIL zero_thr_run_len got %0d exp 1", run_len[7:4]); end
    checks++; if (hit_count !== 16'd3) begin errors++; $display("FAIL zero_thr_hit got %0d exp 3", hit_count); end
  endtask

  task automatic test_saturate();
    min_run = 4'd2;
    for (int k = 0; k < 20; k++) cyc(4'b0100);
    x_in = 4'b0000; #1;
    checks++; if (y_out !== 4'b0100) begin errors++; $display("FAIL sat_y_out got %h exp 4", y_out); end
    @(posedge clock); #1;
    checks++; if (run_len[11:8] !== 4'd15) begin errors++; $display("FAIL sat_run_len got %0d exp 15", run_len[11:8]); end
    checks++; if (hit_count !== 16'd4) begin errors++; $display("FAIL sat_hit got %0d exp 4", hit_count); end
  endtask

  task automatic test_multi();
    clear = 1'b1;
    cyc(4'b0000);
    clear = 1'b0;
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL multi_pre_hit got %0d exp 0", hit_count); end
    min_run = 4'd1;
    cyc(4'b1111); cyc(4'b1111);
    x_in = 4'b0000; #1;
    checks++; if (y_out !== 4'b1111) begin errors++; $display("FAIL multi_y_out got %h exp f", y_out); end
    @(posedge clock); #1;
    checks++; if (hit_count !== 16'd4) begin errors++; $display("FAIL multi_hit got %0d exp 4", hit_count); end
    checks++; if (run_len !== 16'h2222) begin errors++; $display("FAIL multi_run_len got %h exp 2222", run_len); end
    checks++; if (hit_s !== 3'd4) begin errors++; $display("FAIL multi_hit_s got %0d exp 4", hit_s); end
    cyc(4'b0011); cyc(4'b0011); cyc(4'b0000);
    checks++; if (hit_s !== 3'd6) begin errors++; $display("FAIL multi_hit_s6 got %0d exp 6", hit_s); end
    cyc(4'b1111); cyc(4'b1111); cyc(4'b0000);
    checks++; if (hit_count !== 16'd10) begin errors++; $display("FAIL multi_hit10 got %0d exp 10", hit_count); end
    checks++; if (hit_s !== 3'd7) begin errors++; $display("FAIL multi_hit_s_sat got %0d exp 7", hit_s); end
    cyc(4'b1111); cyc(4'b1111); cyc(4'b0000);
    checks++; if (hit_count !== 16'd14) begin errors++; $display("FAIL multi_hit14 got %0d exp 14", hit_count); end
    checks++; if (hit_s !== 3'd7) begin errors++; $display("FAIL multi_hit_s_hold got %0d exp 7", hit_s); end
  endtask

  task automatic test_enable();
    clear = 1'b1;
    cyc(4'b0000);
    clear = 1'b0;
    min_run = 4'd2;
    cyc(4'b1000); cyc(4'b1000);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x_in = 4'b0000; #1;
      checks++; if (y_out !== 4'h0) begin errors++; $display("FAIL en_low_y_out%0d got %h exp 0", k, y_out); end
      @(posedge clock); #1;
      checks++; if (y_reg !== 4'h0) begin errors++; $display("FAIL en_low_y_reg%0d got %h exp 0", k, y_reg); end
    end
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL en_low_hit got %0d exp 0", hit_count); end
    en = 1'b1;
    x_in = 4'b0000; #1;
    checks++; if (y_out !== 4'b1000) begin errors++; $display("FAIL en_det_y_out got %h exp 8", y_out); end
    @(posedge clock); #1;
    checks++; if (y_reg !== 4'b1000) begin errors++; $display("FAIL en_det_y_reg got %h exp 8", y_reg); end
    checks++; if (run_len[15:12] !== 4'd2) begin errors++; $display("FAIL en_run_len got %0d exp 2", run_len[15:12]); end
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL en_hit got %0d exp 1", hit_count); end
  endtask

  task automatic test_reset_mid();
    min_run = 4'd2;
    cyc(4'b0001); cyc(4'b0001); cyc(4'b0001);
    x_in = 4'b0000; #1;
    checks++; if (y_out !== 4'b0001) begin errors++; $display("FAIL rst_pre_y_out got %h exp 1", y_out); end
    reset = 1'b0; #1;
    checks++; if (y_out !== 4'h0) begin errors++; $display("FAIL rst_y_out got %h exp 0", y_out); end
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rst_hit got %0d exp 0", hit_count); end
    checks++; if (run_len !== 16'h0) begin errors++; $display("FAIL rst_run_len got %h exp 0", run_len); end
    reset = 1'b1; #1;
    cyc(4'b0001);
    x_in = 4'b0000; #1;
    checks++; if (y_out !== 4'h0) begin errors++; $display("FAIL rst_after_y_out got %h exp 0", y_out); end
    @(posedge clock); #1;
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rst_after_hit got %0d exp 0", hit_count); end
  endtask

  task automatic test_clear_mid();
    min_run = 4'd1;
    cyc(4'b0001); cyc(4'b0000);
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL clr_pre_hit got %0d exp 1", hit_count); end
    min_run = 4'd2;
    cyc(4'b0001); cyc(4'b0001); cyc(4'b0001);
    clear = 1'b1;
    cyc(4'b0000);
    clear = 1'b0;
    checks++; if (y_reg !== 4'h0) begin errors++; $display("FAIL clr_y_reg got %h exp 0", y_reg); end
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL clr_hit got %0d exp 0", hit_count); end
    checks++; if (run_len !== 16'h0) begin errors++; $display("FAIL clr_run_len got %h exp 0", run_len); end
    checks++; if (hit_s !== 3'd0) begin errors++; $display("FAIL clr_hit_s got %0d exp 0", hit_s); end
    cyc(4'b0001);
    x_in = 4'b0000; #1;
    checks++; if (y_out !== 4'h0) begin errors++; $display("FAIL clr_after_y_out got %h exp 0", y_out); end
    @(posedge clock); #1;
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL clr_after_hit got %0d exp 0", hit_count); end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; en = 1'b0; min_run = 4'd1; x_in = 4'h0;
    #12;
    test_reset();
    test_min1();
    test_min_run();
    test_saturate();
    test_multi();
    test_enable();
    test_reset_mid();
    test_clear_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
